// File: rtl/tile_placer.sv
// Placement front end: reads a target cell and its four neighbours from board RAM,
// consults the legality checker, selects a tile and commits it to the board.
module tile_placer #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int AW          = 6,
  parameter int CHK_TIMEOUT = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_row,
  input  logic [2:0]    req_col,
  input  logic [2:0]    req_pref,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [2:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [2:0]    mem_wr_data,
  output logic          chk_start,
  output logic [2:0]    chk_up,
  output logic [2:0]    chk_down,
  output logic [2:0]    chk_left,
  output logic [2:0]    chk_right,
  input  logic [5:0]    chk_tile_type,
  input  logic          chk_end,
  output logic          done,
  output logic [2:0]    placed_tile,
  output logic          illegal
);
  localparam int WW = (CHK_TIMEOUT > 1) ? $clog2(CHK_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_CHECK, S_WAIT, S_DECIDE, S_WRITE, S_DONE
  } state_t;

  state_t state, state_next;

  logic [2:0]    row_q, col_q, pref_q;
  logic [2:0]    slot;
  logic          prev_rd;
  logic [2:0]    self_q, up_q, down_q, left_q, right_q;
  logic [5:0]    mask_q;
  logic [WW-1:0] wait_cnt;
  logic [2:0]    tile_q;

  logic [2:0]    rd_cap;
  logic          in_range;
  logic          slot_ok;
  logic [AW-1:0] slot_addr;
  logic [7:0]    mask_ext;
  logic          pick_ok;
  logic [2:0]    pick_tile;
  logic          finish;
  logic          finish_illegal;

  function automatic logic [AW-1:0] cell_addr(input int r, input int c);
    return AW'(r * COLS + c);
  endfunction

  always_comb begin
    // Off-board slots never strobe the RAM, so whatever is on the bus is discarded.
    rd_cap   = prev_rd ? mem_rd_data : '0;
    in_range = (int'(req_row) < ROWS) && (int'(req_col) < COLS);

    slot_ok   = 1'b0;
    slot_addr = '0;
    case (slot)
      3'd0: begin
        slot_ok   = 1'b1;
        slot_addr = cell_addr(int'(row_q), int'(col_q));
      end
      3'd1: begin
        slot_ok   = (row_q != 3'd0);
        slot_addr = cell_addr(int'(row_q) - 1, int'(col_q));
      end
      3'd2: begin
        slot_ok   = (int'(row_q) < ROWS - 1);
        slot_addr = cell_addr(int'(row_q) + 1, int'(col_q));
      end
      3'd3: begin
        slot_ok   = (col_q != 3'd0);
        slot_addr = cell_addr(int'(row_q), int'(col_q) - 1);
      end
      3'd4: begin
        slot_ok   = (int'(col_q) < COLS - 1);
        slot_addr = cell_addr(int'(row_q), int'(col_q) + 1);
      end
      default: ;
    endcase

    // Bit k of mask_ext stands for tile code k; codes 0 and 7 are never legal.
    mask_ext  = {1'b0, mask_q, 1'b0};
    pick_ok   = 1'b0;
    pick_tile = '0;
    if (pref_q == 3'd0) begin
      for (int unsigned k = 6; k >= 1; k--) begin
        if (mask_ext[3'(k)]) begin
          pick_ok   = 1'b1;
          pick_tile = 3'(k);
        end
      end
    end else if (mask_ext[pref_q]) begin
      pick_ok   = 1'b1;
      pick_tile = pref_q;
    end
  end

  always_comb begin
    state_next     = state;
    finish         = 1'b0;
    finish_illegal = 1'b0;
    req_ready      = 1'b0;
    mem_rd_en      = 1'b0;
    mem_addr       = '0;
    mem_wr_en      = 1'b0;
    mem_wr_data    = '0;
    chk_start      = 1'b0;
    done           = 1'b0;
    chk_up         = '0;
    chk_down       = '0;
    chk_left       = '0;
    chk_right      = '0;

    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (in_range) begin
            state_next = S_READ;
          end else begin
            state_next     = S_DONE;
            finish         = 1'b1;
            finish_illegal = 1'b1;
          end
        end
      end
      S_READ: begin
        mem_rd_en = slot_ok;
        mem_addr  = slot_ok ? slot_addr : '0;
        if (slot == 3'd4) state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (self_q != 3'd0) begin
          state_next     = S_DONE;
          finish         = 1'b1;
          finish_illegal = 1'b1;
        end else if ({up_q, down_q, left_q, rd_cap} == '0) begin
          state_next = S_DECIDE;
        end else begin
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        chk_start  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (chk_end) begin
          state_next = S_DECIDE;
        end else if (wait_cnt == WW'(CHK_TIMEOUT - 1)) begin
          state_next     = S_DONE;
          finish         = 1'b1;
          finish_illegal = 1'b1;
        end
      end
      S_DECIDE: begin
        if (pick_ok) begin
          state_next = S_WRITE;
        end else begin
          state_next     = S_DONE;
          finish         = 1'b1;
          finish_illegal = 1'b1;
        end
      end
      S_WRITE: begin
        mem_wr_en   = 1'b1;
        mem_addr    = cell_addr(int'(row_q), int'(col_q));
        mem_wr_data = tile_q;
        state_next  = S_DONE;
        finish      = 1'b1;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    if (state inside {S_CHECK, S_WAIT, S_DECIDE, S_WRITE, S_DONE}) begin
      chk_up    = up_q;
      chk_down  = down_q;
      chk_left  = left_q;
      chk_right = right_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      pref_q      <= '0;
      slot        <= '0;
      prev_rd     <= 1'b0;
      self_q      <= '0;
      up_q        <= '0;
      down_q      <= '0;
      left_q      <= '0;
      right_q     <= '0;
      mask_q      <= '0;
      wait_cnt    <= '0;
      tile_q      <= '0;
      placed_tile <= '0;
      illegal     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            row_q       <= req_row;
            col_q       <= req_col;
            pref_q      <= req_pref;
            slot        <= '0;
            prev_rd     <= 1'b0;
            self_q      <= '0;
            up_q        <= '0;
            down_q      <= '0;
            left_q      <= '0;
            right_q     <= '0;
            placed_tile <= '0;
            illegal     <= 1'b0;
          end
        end
        S_READ: begin
          prev_rd <= mem_rd_en;
          slot    <= slot + 3'd1;
          case (slot)
            3'd1: self_q <= rd_cap;
            3'd2: up_q   <= rd_cap;
            3'd3: down_q <= rd_cap;
            3'd4: left_q <= rd_cap;
            default: ;
          endcase
        end
        S_CAPTURE: begin
          right_q <= rd_cap;
          // Isolated-cell mask; the checker path overwrites it when chk_end arrives.
          mask_q  <= '1;
        end
        S_CHECK: wait_cnt <= '0;
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (chk_end) mask_q <= chk_tile_type;
        end
        S_DECIDE: tile_q <= pick_tile;
        default: ;
      endcase
      // Placed after the IDLE clears so an out-of-range reject still reports illegal.
      if (finish) begin
        illegal     <= finish_illegal;
        placed_tile <= finish_illegal ? '0 : tile_q;
      end
    end
  end

endmodule

// File: tb/tb_tile_placer.sv
// Bench for tile_placer: board RAM and checker environment, a cycle-level expectation
// built from the placement rules, directed cases then randomized requests.
`timescale 1ns/1ps
module tb_tile_placer;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int AW   = 6;
  localparam int TMO  = 15;
  localparam int TMAX = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_row, req_col, req_pref;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_rd_data = '0;
  logic          mem_wr_en;
  logic [2:0]    mem_wr_data;
  logic          chk_start;
  logic [2:0]    chk_up, chk_down, chk_left, chk_right;
  logic [5:0]    chk_tile_type;
  logic          chk_end;
  logic          done;
  logic [2:0]    placed_tile;
  logic          illegal;

  tile_placer #(.ROWS(ROWS), .COLS(COLS), .AW(AW), .CHK_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_col(req_col), .req_pref(req_pref),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .chk_start(chk_start),
    .chk_up(chk_up), .chk_down(chk_down), .chk_left(chk_left), .chk_right(chk_right),
    .chk_tile_type(chk_tile_type), .chk_end(chk_end),
    .done(done), .placed_tile(placed_tile), .illegal(illegal)
  );

  always #5 clock = ~clock;

  // Board RAM: one-cycle read latency, garbage on the bus when not read.
  logic [2:0]    board [0:ROWS*COLS-1];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_a  = '0;
  logic [2:0]    poke_v  = '0;

  always @(posedge clock) begin
    mem_rd_data <= mem_rd_en ? board[mem_addr] : 3'($urandom_range(7, 0));
    if (poke_en) board[poke_a] <= poke_v;
    else if (mem_wr_en) board[mem_addr] <= mem_wr_data;
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [13:0] exp_vec [0:TMAX];
  int          exp_len;
  int          nb_from;
  int          end_t;
  bit          cs_path;
  logic [2:0]  exp_placed;
  logic        exp_illegal;
  logic [11:0] exp_nb;

  int          rd_log[$];
  int          wr_cnt;
  int          last_done_t;

  task automatic check(input string name, input int t, input logic [31:0] act,
                       input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s (t=%0d): got %0h, expected %0h", name, t, act, expv);
    end
  endtask

  function automatic logic [13:0] vec(input logic rdy, input logic rd, input logic wr,
                                      input int a, input int wd, input logic cs,
                                      input logic dn);
    return {rdy, rd, wr, 6'(a), 3'(wd), cs, dn};
  endfunction

  function automatic void decide(input logic [5:0] mask, input int p,
                                 output bit ok, output logic [2:0] tile);
    ok   = 1'b0;
    tile = '0;
    if (p == 0) begin
      for (int k = 1; k <= 6; k++)
        if (!ok && mask[3'(k - 1)]) begin ok = 1'b1; tile = 3'(k); end
    end else if (p <= 6) begin
      if (mask[3'(p - 1)]) begin ok = 1'b1; tile = 3'(p); end
    end
  endfunction

  // Expected cycle-by-cycle outputs (t = cycles after the accepting edge).
  task automatic build_model(input int r, input int c, input int p, input int d,
                             input logic [5:0] m);
    int         r_off[5] = '{0, -1, 1, 0, 0};
    int         c_off[5] = '{0, 0, 0, -1, 1};
    int         ar[5];
    bit         ok[5];
    logic [2:0] v[5];
    logic [5:0] mask;
    logic [2:0] tile;
    bit         legal;
    int         base;
    for (int k = 0; k < 5; k++) begin
      int rr = r + r_off[k];
      int cc = c + c_off[k];
      ok[k] = (rr >= 0) && (rr < ROWS) && (cc >= 0) && (cc < COLS);
      ar[k] = ok[k] ? rr * COLS + cc : 0;
      v[k]  = ok[k] ? board[6'(ar[k])] : 3'd0;
    end
    for (int t = 0; t <= TMAX; t++) exp_vec[t] = vec(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) exp_vec[1 + k] = vec(0, ok[k], 0, ar[k], 0, 0, 0);
    exp_nb  = {v[1], v[2], v[3], v[4]};
    end_t   = -1;
    cs_path = 1'b0;
    nb_from = 0;
    legal   = 1'b0;
    tile    = '0;
    mask    = '0;
    base    = -1;
    if (v[0] != 3'd0) begin
      exp_len = 7;
    end else begin
      if (exp_nb == '0) begin
        mask = 6'h3f;
        base = 7;
      end else begin
        cs_path    = 1'b1;
        nb_from    = 7;
        exp_vec[7] = vec(0, 0, 0, 0, 0, 1, 0);
        if (d >= 0) end_t = 8 + d;
        if (d >= 0 && d < TMO) begin
          mask = m;
          base = 9 + d;
        end
      end
      if (base < 0) begin
        exp_len = 8 + TMO;
      end else begin
        decide(mask, p, legal, tile);
        if (legal) begin
          exp_vec[base + 1] = vec(0, 0, 1, ar[0], int'(tile), 0, 0);
          exp_len = base + 2;
        end else begin
          exp_len = base + 1;
        end
      end
    end
    exp_vec[exp_len]     = vec(0, 0, 0, 0, 0, 0, 1);
    exp_vec[exp_len + 1] = vec(1, 0, 0, 0, 0, 0, 0);
    exp_vec[exp_len + 2] = vec(1, 0, 0, 0, 0, 0, 0);
    exp_placed  = legal ? tile : 3'd0;
    exp_illegal = !legal;
    if (nb_from == 0) nb_from = exp_len;
  endtask

  task automatic compare(input int t);
    logic [13:0] act;
    act = vec(req_ready, mem_rd_en, mem_wr_en,
              (mem_rd_en || mem_wr_en) ? int'(mem_addr) : 0,
              mem_wr_en ? int'(mem_wr_data) : 0, chk_start, done);
    check("cycle", t, {18'd0, act}, {18'd0, exp_vec[t]});
    if (mem_rd_en) rd_log.push_back(int'(mem_addr));
    if (mem_wr_en) wr_cnt++;
    if (done) last_done_t = t;
    if (t >= nb_from && t <= exp_len)
      check("nbrs", t, {20'd0, chk_up, chk_down, chk_left, chk_right}, {20'd0, exp_nb});
    if (t >= exp_len) begin
      check("placed", t, {29'd0, placed_tile}, {29'd0, exp_placed});
      check("illegal", t, {31'd0, illegal}, {31'd0, exp_illegal});
    end
  endtask

  task automatic poke(input int a, input int v);
    @(negedge clock);
    poke_en = 1'b1;
    poke_a  = AW'(a);
    poke_v  = 3'(v);
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  task automatic run_req(input int r, input int c, input int p, input int d,
                         input bit stale, input logic [5:0] m, input int abort_t);
    build_model(r, c, p, d, m);
    @(negedge clock);
    check("ready", 0, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_row   = 3'(r);
    req_col   = 3'(c);
    req_pref  = 3'(p);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_row   = 3'($urandom);
    req_col   = 3'($urandom);
    req_pref  = 3'($urandom);
    rd_log.delete();
    wr_cnt      = 0;
    last_done_t = -1;
    for (int t = 1; t <= exp_len + 2; t++) begin
      chk_end       = cs_path && ((t == end_t) || (stale && t == 7));
      chk_tile_type = (t == end_t) ? m : 6'($urandom);
      @(negedge clock);
      compare(t);
      if (t == abort_t) break;
      @(posedge clock);
      #1;
    end
    chk_end = 1'b0;
  endtask

  initial begin
    int exp_rd33[5] = '{27, 19, 35, 26, 28};
    int exp_rd00[3] = '{0, 8, 1};
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_row       = '0;
    req_col       = '0;
    req_pref      = '0;
    chk_end       = 1'b0;
    chk_tile_type = '0;
    for (int i = 0; i < ROWS * COLS; i++) poke(i, 0);
    @(negedge clock);
    check("reset_outs", 0,
          {18'd0, vec(req_ready, mem_rd_en, mem_wr_en, int'(mem_addr), int'(mem_wr_data),
                      chk_start, done)},
          {18'd0, vec(1, 0, 0, 0, 0, 0, 0)});
    check("reset_result", 0, {28'd0, placed_tile, illegal}, 32'd0);
    reset = 1'b0;

    // Isolated centre cell, auto-select.
    run_req(3, 3, 0, -1, 0, '0, 0);
    check("rd33_count", 0, rd_log.size(), 5);
    for (int i = 0; i < 5 && i < rd_log.size(); i++) check("rd33_addr", i, rd_log[i], exp_rd33[i]);
    check("wr33_board", 0, {29'd0, board[27]}, 32'd1);
    check("lat33", 0, last_done_t, 9);
    check("placed33", 0, {29'd0, placed_tile}, 32'd1);

    // Corner cell: only self/down/right are read.
    run_req(0, 0, 0, -1, 0, '0, 0);
    check("rd00_count", 0, rd_log.size(), 3);
    for (int i = 0; i < 3 && i < rd_log.size(); i++) check("rd00_addr", i, rd_log[i], exp_rd00[i]);
    check("wr00_board", 0, {29'd0, board[0]}, 32'd1);

    // Occupied target.
    poke(2 * COLS + 5, 4);
    run_req(2, 5, 0, -1, 0, '0, 0);
    check("occ_illegal", 0, {28'd0, placed_tile, illegal}, 32'd1);
    check("occ_nowrite", 0, wr_cnt, 0);

    // Checker path with a stale chk_end during the start cycle.
    poke(3 * COLS + 4, 3);
    run_req(4, 4, 4, 2, 1, 6'b001100, 0);
    check("chk_board", 0, {29'd0, board[36]}, 32'd4);
    check("chk_lat", 0, last_done_t, 13);
    poke(36, 0);
    run_req(4, 4, 1, 2, 0, 6'b001100, 0);
    check("pref_clear_illegal", 0, {28'd0, placed_tile, illegal}, 32'd1);
    check("pref_clear_nowrite", 0, wr_cnt, 0);

    // Checker never answers.
    run_req(4, 4, 0, -1, 0, '0, 0);
    check("tmo_lat", 0, last_done_t, 8 + TMO);
    check("tmo_nowrite", 0, wr_cnt, 0);

    // Reset while waiting on the checker.
    run_req(4, 4, 0, -1, 0, '0, 12);
    #2 reset = 1'b1;
    #1;
    check("rst_outs", 0,
          {18'd0, vec(req_ready, mem_rd_en, mem_wr_en, int'(mem_addr), int'(mem_wr_data),
                      chk_start, done)},
          {18'd0, vec(1, 0, 0, 0, 0, 0, 0)});
    check("rst_result", 0, {28'd0, placed_tile, illegal}, 32'd0);
    check("rst_nbrs", 0, {20'd0, chk_up, chk_down, chk_left, chk_right}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("rst_idle", i, {29'd0, done, mem_wr_en, req_ready}, 32'd1);
    end
    check("rst_nowrite", 0, {29'd0, board[36]}, 32'd0);
    run_req(4, 4, 0, 1, 0, 6'b010000, 0);
    check("post_rst_board", 0, {29'd0, board[36]}, 32'd5);
    check("post_rst_lat", 0, last_done_t, 12);

    // Randomized requests on an evolving board.
    for (int n = 0; n < 40; n++) begin
      int r = $urandom_range(ROWS - 1, 0);
      int c = $urandom_range(COLS - 1, 0);
      int d = ($urandom_range(4, 0) == 0) ? -1 : int'($urandom_range(TMO + 2, 0));
      for (int j = 0; j < 2; j++)
        poke($urandom_range(ROWS * COLS - 1, 0),
             $urandom_range(1, 0) ? 0 : int'($urandom_range(6, 1)));
      if ($urandom_range(1, 0) == 1) poke(r * COLS + c, 0);
      run_req(r, c, $urandom_range(7, 0), d, 1'($urandom_range(1, 0)),
              6'($urandom_range(63, 0)), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
